fifo_converter_64to32b: RTL and testbench

FIFO_CONVERTER_64TO32B -- requirements
Module: fifo_converter_64to32b

---
 rtl/fifo_converter_64to32b.sv | 115 +++++++++++
 tb/tb_fifo_converter_64to32b.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_converter_64to32b.sv
// Drains a 64-bit FWFT source FIFO into a 32-bit destination FIFO, one half per cycle.
// HI_FIRST selects which half of each 64-bit word is written first.
module fifo_converter_64to32b #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        digiclk_i,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        cnt_clr_i,
    input  logic        src_empty_i,
    input  logic [63:0] src_data_64bit_i,
    output logic        src_re_o,
    input  logic        dst_afull_i,
    output logic        dst_we_o,
    output logic [31:0] dst_data_32bit_o,
    output logic        busy_o,
    output logic [31:0] word_cnt_o
);

    typedef enum logic [1:0] {
        Idle       = 2'b00,
        SendFirst  = 2'b01,
        SendSecond = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        enable_r;
    logic        load_ok;
    logic        load_hold;
    logic        src_re;
    logic [63:0] hold_q;
    logic [31:0] first_half, second_half;
    logic        dst_we_d;
    logic [31:0] dst_data_d;
    logic        dst_we_q;
    logic [31:0] dst_data_q;
    logic [31:0] word_cnt_q;

    assign load_ok     = enable_r & ~src_empty_i & ~dst_afull_i;
    assign first_half  = HI_FIRST ? hold_q[63:32] : hold_q[31:0];
    assign second_half = HI_FIRST ? hold_q[31:0]  : hold_q[63:32];

    // Once a word is held, SendFirst always advances to SendSecond so a pair is never split.
    always_comb begin
        state_d    = state_q;
        load_hold  = 1'b0;
        src_re     = 1'b0;
        dst_we_d   = 1'b0;
        dst_data_d = dst_data_q;
        case (state_q)
            Idle: begin
                if (load_ok) begin
                    src_re    = 1'b1;
                    load_hold = 1'b1;
                    state_d   = SendFirst;
                end
            end
            SendFirst: begin
                dst_we_d   = 1'b1;
                dst_data_d = first_half;
                state_d    = SendSecond;
            end
            SendSecond: begin
                dst_we_d   = 1'b1;
                dst_data_d = second_half;
                if (load_ok) begin
                    src_re    = 1'b1;
                    load_hold = 1'b1;
                    state_d   = SendFirst;
                end else begin
                    state_d = Idle;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    always_ff @(posedge digiclk_i or posedge reset) begin
        if (reset) begin
            state_q    <= Idle;
            enable_r   <= 1'b0;
            hold_q     <= 64'd0;
            dst_we_q   <= 1'b0;
            dst_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            enable_r   <= enable_i;
            dst_we_q   <= dst_we_d;
            dst_data_q <= dst_data_d;
            if (load_hold) begin
                hold_q <= src_data_64bit_i;
            end
        end
    end

    // Counts alongside the write enable register; a clear on the same edge wins.
    always_ff @(posedge digiclk_i or posedge reset) begin
        if (reset) begin
            word_cnt_q <= 32'd0;
        end else if (cnt_clr_i) begin
            word_cnt_q <= 32'd0;
        end else if (dst_we_d) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign src_re_o         = src_re & ~reset;
    assign dst_we_o         = dst_we_q;
    assign dst_data_32bit_o = dst_data_q;
    assign busy_o           = (state_q != Idle);
    assign word_cnt_o       = word_cnt_q;

endmodule

// File: tb/tb_fifo_converter_64to32b.sv
// Directed bench: a queue models the source FWFT FIFO, writes are logged from both
// HI_FIRST variants and compared against hand-computed halves.
module tb_fifo_converter_64to32b;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cnt_clr;
    logic        src_empty;
    logic [63:0] src_data;
    logic        dst_afull;
    logic        src_re, src_re_lo;
    logic        dst_we, dst_we_lo;
    logic [31:0] dst_data, dst_data_lo;
    logic        busy, busy_lo;
    logic [31:0] word_cnt, word_cnt_lo;

    fifo_converter_64to32b #(.HI_FIRST(1'b1)) dut (
        .digiclk_i        (clk),
        .reset            (reset),
        .enable_i         (enable),
        .cnt_clr_i        (cnt_clr),
        .src_empty_i      (src_empty),
        .src_data_64bit_i (src_data),
        .src_re_o         (src_re),
        .dst_afull_i      (dst_afull),
        .dst_we_o         (dst_we),
        .dst_data_32bit_o (dst_data),
        .busy_o           (busy),
        .word_cnt_o       (word_cnt)
    );

    fifo_converter_64to32b #(.HI_FIRST(1'b0)) dut_lo (
        .digiclk_i        (clk),
        .reset            (reset),
        .enable_i         (enable),
        .cnt_clr_i        (cnt_clr),
        .src_empty_i      (src_empty),
        .src_data_64bit_i (src_data),
        .src_re_o         (src_re_lo),
        .dst_afull_i      (dst_afull),
        .dst_we_o         (dst_we_lo),
        .dst_data_32bit_o (dst_data_lo),
        .busy_o           (busy_lo),
        .word_cnt_o       (word_cnt_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [31:0] hi_a;
        logic [31:0] hi_b;
        logic [31:0] lo_a;
        logic [31:0] lo_b;
    } vec_t;

    vec_t        vecs[4];
    logic [63:0] src_q[$];
    logic [31:0] wq[$];
    logic [31:0] wq_lo[$];
    int          wcyc[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          pops   = 0;
    logic        last_re;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wat(input bit lo, input int i);
        if (lo) return (i < wq_lo.size()) ? wq_lo[i] : 32'hxxxx_xxxx;
        return (i < wq.size()) ? wq[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic void refresh();
        src_empty = (src_q.size() == 0);
        src_data  = src_empty ? 64'd0 : src_q[0];
    endfunction

    function automatic void clear_log();
        wq.delete();
        wq_lo.delete();
        wcyc.delete();
    endfunction

    // One clock: sample the pop request mid-cycle, then log what is registered after the edge.
    task automatic step();
        @(negedge clk);
        last_re = src_re;
        check("re_when_empty", {63'd0, src_re & src_empty}, 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        if (last_re && src_q.size() > 0) begin
            void'(src_q.pop_front());
            pops++;
        end
        if (dst_we) begin
            wq.push_back(dst_data);
            wcyc.push_back(cyc);
        end
        if (dst_we_lo) wq_lo.push_back(dst_data_lo);
        refresh();
    endtask

    initial begin
        int          pops0;
        logic [31:0] cnt0;
        bit          seen;

        vecs[0] = '{64'hAAAAAAAA_55555555, 32'hAAAAAAAA, 32'h55555555, 32'h55555555, 32'hAAAAAAAA};
        vecs[1] = '{64'hDEADBEEF_01234567, 32'hDEADBEEF, 32'h01234567, 32'h01234567, 32'hDEADBEEF};
        vecs[2] = '{64'hFFFFFFFF_00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[3] = '{64'h01234567_89ABCDEF, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h01234567};

        reset     = 1'b1;
        enable    = 1'b1;
        cnt_clr   = 1'b0;
        dst_afull = 1'b0;
        last_re   = 1'b0;
        src_q.push_back(64'h11112222_33334444);
        refresh();
        repeat (3) @(posedge clk);
        #1;
        check("rst_src_re", {63'd0, src_re}, 64'd0);
        check("rst_dst_we", {63'd0, dst_we}, 64'd0);
        check("rst_dst_data", {32'd0, dst_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_word_cnt", {32'd0, word_cnt}, 64'd0);

        // Single word after release: no pop on the first edge, then one pop.
        reset = 1'b0;
        clear_log();
        step();
        check("rel_first_re", {63'd0, last_re}, 64'd0);
        step();
        check("rel_second_re", {63'd0, last_re}, 64'd1);
        repeat (6) step();
        check("single_nwrites", wq.size(), 2);
        check("single_w0", {32'd0, wat(0, 0)}, {32'd0, 32'h11112222});
        check("single_w1", {32'd0, wat(0, 1)}, {32'd0, 32'h33334444});
        check("single_lo_w0", {32'd0, wat(1, 0)}, {32'd0, 32'h33334444});
        check("single_consec", wcyc.size() == 2 ? wcyc[1] - wcyc[0] : -1, 1);
        check("single_cnt", {32'd0, word_cnt}, 64'd2);
        check("single_pops", pops, 1);
        check("single_idle", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            clear_log();
            pops0 = pops;
            cnt0  = word_cnt;
            src_q.push_back(vecs[i].word);
            refresh();
            repeat (6) step();
            check($sformatf("vec%0d_nwrites", i), wq.size(), 2);
            check($sformatf("vec%0d_hi_a", i), {32'd0, wat(0, 0)}, {32'd0, vecs[i].hi_a});
            check($sformatf("vec%0d_hi_b", i), {32'd0, wat(0, 1)}, {32'd0, vecs[i].hi_b});
            check($sformatf("vec%0d_lo_a", i), {32'd0, wat(1, 0)}, {32'd0, vecs[i].lo_a});
            check($sformatf("vec%0d_lo_b", i), {32'd0, wat(1, 1)}, {32'd0, vecs[i].lo_b});
            check($sformatf("vec%0d_cnt", i), {32'd0, word_cnt - cnt0}, 64'd2);
            check($sformatf("vec%0d_pops", i), pops - pops0, 1);
        end

        // Streaming: eight words must produce sixteen back-to-back writes.
        clear_log();
        pops0 = pops;
        cnt0  = word_cnt;
        for (int i = 0; i < 8; i++) src_q.push_back({32'h1000_0000 + i, 32'h2000_0000 + i});
        refresh();
        repeat (24) step();
        check("stream_nwrites", wq.size(), 16);
        check("stream_pops", pops - pops0, 8);
        check("stream_nogap", wcyc.size() == 16 ? wcyc[15] - wcyc[0] : -1, 15);
        check("stream_cnt", {32'd0, word_cnt - cnt0}, 64'd16);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_w%0d_hi", i), {32'd0, wat(0, 2 * i)},
                  {32'd0, 32'h1000_0000 + i});
            check($sformatf("stream_w%0d_lo", i), {32'd0, wat(0, 2 * i + 1)},
                  {32'd0, 32'h2000_0000 + i});
        end

        // Backpressure raised while the first half is pending.
        clear_log();
        pops0 = pops;
        src_q.push_back(64'hCAFEF00D_12345678);
        src_q.push_back(64'h0BADC0DE_87654321);
        refresh();
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            seen = last_re;
        end
        check("bp_load_seen", {63'd0, seen}, 64'd1);
        dst_afull = 1'b1;
        repeat (6) step();
        check("bp_nwrites", wq.size(), 2);
        check("bp_w0", {32'd0, wat(0, 0)}, {32'd0, 32'hCAFEF00D});
        check("bp_w1", {32'd0, wat(0, 1)}, {32'd0, 32'h12345678});
        check("bp_pops_held", pops - pops0, 1);
        check("bp_idle", {63'd0, busy}, 64'd0);
        dst_afull = 1'b0;
        repeat (6) step();
        check("bp_resume_nwrites", wq.size(), 4);
        check("bp_w2", {32'd0, wat(0, 2)}, {32'd0, 32'h0BADC0DE});
        check("bp_w3", {32'd0, wat(0, 3)}, {32'd0, 32'h87654321});
        check("bp_pops_resume", pops - pops0, 2);

        // Reset in SendSecond drops the pending half; the queued word loads after release.
        clear_log();
        src_q.push_back(64'h01010101_02020202);
        src_q.push_back(64'h03030303_04040404);
        refresh();
        step();
        step();
        check("mid_first_half", {32'd0, wat(0, 0)}, {32'd0, 32'h01010101});
        reset = 1'b1;
        #1;
        check("mid_rst_we", {63'd0, dst_we}, 64'd0);
        check("mid_rst_data", {32'd0, dst_data}, 64'd0);
        check("mid_rst_cnt", {32'd0, word_cnt}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_re", {63'd0, src_re}, 64'd0);
        repeat (2) step();
        reset = 1'b0;
        clear_log();
        repeat (8) step();
        check("mid_after_nwrites", wq.size(), 2);
        check("mid_after_w0", {32'd0, wat(0, 0)}, {32'd0, 32'h03030303});
        check("mid_after_w1", {32'd0, wat(0, 1)}, {32'd0, 32'h04040404});
        check("mid_after_cnt", {32'd0, word_cnt}, 64'd2);

        // Counter wrap from a preloaded all-ones value, then clear during writes.
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #2;
        release dut.word_cnt_q;
        clear_log();
        src_q.push_back(64'h13572468_9ABCDEF0);
        refresh();
        step();
        step();
        check("wrap_first_write", wq.size(), 1);
        check("wrap_cnt0", {32'd0, word_cnt}, 64'd0);
        step();
        check("wrap_cnt1", {32'd0, word_cnt}, 64'd1);
        repeat (3) step();
        cnt_clr = 1'b1;
        clear_log();
        src_q.push_back(64'h2468ACE0_13579BDF);
        refresh();
        repeat (6) step();
        check("clr_nwrites", wq.size(), 2);
        check("clr_cnt", {32'd0, word_cnt}, 64'd0);
        cnt_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
